// File: rtl/dual_cam_line_arbiter.sv
// dual_cam_line_arbiter: alternates complete cam0/cam1 lines onto one tagged byte stream,
// owns the cam FIFO flush and counts completed dual-camera frames.
module dual_cam_line_arbiter #(
    parameter int IM_X       = 1280,
    parameter int IM_Y       = 720,
    parameter int COLOR_MODE = 1,
    parameter int FIFO_AW    = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_stream,
    input  logic [FIFO_AW-1:0] cam0_usedw,
    input  logic               cam0_empty,
    input  logic [7:0]         cam0_q,
    output logic               cam0_rdreq,
    input  logic [FIFO_AW-1:0] cam1_usedw,
    input  logic               cam1_empty,
    input  logic [7:0]         cam1_q,
    output logic               cam1_rdreq,
    output logic               fifo_flush,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_cam,
    output logic               busy,
    output logic [15:0]        frame_cnt
);
    localparam int LINE_BYTES = IM_X * COLOR_MODE;
    localparam int BW = LINE_BYTES > 1 ? $clog2(LINE_BYTES) : 1;
    localparam int LW = IM_Y > 1 ? $clog2(IM_Y) : 1;
    localparam logic [FIFO_AW-1:0] LB = FIFO_AW'(LINE_BYTES);
    localparam logic [BW-1:0] LAST_BYTE = BW'(LINE_BYTES - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(IM_Y - 1);

    generate
        if (LINE_BYTES > 2 ** FIFO_AW - 1) begin : g_size_err
            $error("LINE_BYTES does not fit in the camera FIFO fill level");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT_LINE, BURST, LINE_DONE} state_t;

    state_t          state, state_n;
    logic            cur_cam, cur_cam_n;
    logic [LW-1:0]   line_cnt, line_cnt_n;
    logic [BW-1:0]   byte_cnt, byte_cnt_n;
    logic            frame_inc;
    logic            sel_empty, hs, last_byte;
    logic [7:0]      sel_q;
    logic [FIFO_AW-1:0] sel_usedw;

    assign sel_empty  = cur_cam ? cam1_empty : cam0_empty;
    assign sel_q      = cur_cam ? cam1_q : cam0_q;
    assign sel_usedw  = cur_cam ? cam1_usedw : cam0_usedw;
    assign last_byte  = byte_cnt == LAST_BYTE;
    assign out_valid  = state == BURST && !sel_empty;
    assign hs         = out_valid && out_ready;
    assign cam0_rdreq = hs && !cur_cam;
    assign cam1_rdreq = hs && cur_cam;
    assign out_data   = state == BURST ? sel_q : 8'h00;
    assign out_sof    = out_valid && !cur_cam && line_cnt == '0 && byte_cnt == '0;
    assign out_eol    = out_valid && last_byte;
    assign out_cam    = cur_cam;
    assign busy       = state != IDLE;
    // Reset must never clear the FIFOs, even with start_stream already high.
    assign fifo_flush = state == IDLE && start_stream && !rst;

    always_comb begin
        state_n    = state;
        cur_cam_n  = cur_cam;
        line_cnt_n = line_cnt;
        byte_cnt_n = byte_cnt;
        frame_inc  = 1'b0;
        case (state)
            IDLE: if (start_stream) begin
                state_n    = WAIT_LINE;
                cur_cam_n  = 1'b0;
                line_cnt_n = '0;
            end
            WAIT_LINE: if (!start_stream) state_n = IDLE;
                       else if (sel_usedw >= LB) begin
                           state_n    = BURST;
                           byte_cnt_n = '0;
                       end
            BURST: if (hs) begin
                byte_cnt_n = last_byte ? '0 : byte_cnt + 1'b1;
                state_n    = last_byte ? LINE_DONE : BURST;
            end
            default: begin
                cur_cam_n  = !cur_cam;
                frame_inc  = cur_cam && line_cnt == LAST_LINE;
                line_cnt_n = !cur_cam ? line_cnt : frame_inc ? '0 : line_cnt + 1'b1;
                state_n    = start_stream ? WAIT_LINE : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_cam   <= 1'b0;
            line_cnt  <= '0;
            byte_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            cur_cam   <= cur_cam_n;
            line_cnt  <= line_cnt_n;
            byte_cnt  <= byte_cnt_n;
            frame_cnt <= frame_cnt + {15'd0, frame_inc};
        end
    end
endmodule

// File: tb/tb_dual_cam_line_arbiter.sv
// tb_dual_cam_line_arbiter: scoreboard bench with show-ahead FIFO models on both camera inputs.
module tb_dual_cam_line_arbiter;
    localparam int FIFO_AW = 4;

    logic clk = 1'b0;
    logic rst, start_stream, out_ready;
    logic [FIFO_AW-1:0] cam0_usedw, cam1_usedw;
    logic cam0_empty, cam1_empty, cam0_rdreq, cam1_rdreq, fifo_flush;
    logic [7:0] cam0_q, cam1_q, out_data;
    logic out_valid, out_sof, out_eol, out_cam, busy;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    dual_cam_line_arbiter #(.IM_X(4), .IM_Y(2), .COLOR_MODE(1), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .rst(rst), .start_stream(start_stream),
        .cam0_usedw(cam0_usedw), .cam0_empty(cam0_empty), .cam0_q(cam0_q), .cam0_rdreq(cam0_rdreq),
        .cam1_usedw(cam1_usedw), .cam1_empty(cam1_empty), .cam1_q(cam1_q), .cam1_rdreq(cam1_rdreq),
        .fifo_flush(fifo_flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eol(out_eol), .out_cam(out_cam), .busy(busy), .frame_cnt(frame_cnt)
    );

    // Show-ahead FIFO models: pushes from stimulus, pops/flush on the DUT's requests.
    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [4:0] wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    int hs_cnt = 0, p1_cnt = 0, flush_cnt = 0;

    assign cam0_usedw = 4'(wp0 - rp0);
    assign cam1_usedw = 4'(wp1 - rp1);
    assign cam0_empty = wp0 == rp0;
    assign cam1_empty = wp1 == rp1;
    assign cam0_q     = mem0[rp0[3:0]];
    assign cam1_q     = mem1[rp1[3:0]];

    always @(posedge clk) begin
        if (fifo_flush) begin
            rp0 <= wp0;
            rp1 <= wp1;
            flush_cnt <= flush_cnt + 1;
        end else begin
            if (cam0_rdreq) rp0 <= rp0 + 5'd1;
            if (cam1_rdreq) rp1 <= rp1 + 5'd1;
        end
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
        if (cam1_rdreq) p1_cnt <= p1_cnt + 1;
    end

    typedef struct {
        logic [7:0] d;
        logic sof;
        logic eol;
        logic cam;
    } exp_t;
    exp_t exp_q[$];
    string chk_n[$];
    int chk_a[$];
    int chk_e[$];
    int checks = 0, errors = 0;

    // Single checker process: bytes on every handshake, plus queued direct checks.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got data=%02h cam=%0d", out_data, out_cam);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.d || out_sof !== e.sof || out_eol !== e.eol || out_cam !== e.cam) begin
                    errors++;
                    $display("FAIL byte got d=%02h sof=%0d eol=%0d cam=%0d want d=%02h sof=%0d eol=%0d cam=%0d",
                             out_data, out_sof, out_eol, out_cam, e.d, e.sof, e.eol, e.cam);
                end
            end
        end
        while (chk_n.size() != 0) begin
            string n;
            int a, x;
            n = chk_n.pop_front();
            a = chk_a.pop_front();
            x = chk_e.pop_front();
            checks++;
            if (a != x) begin
                errors++;
                $display("FAIL %s got %0d want %0d", n, a, x);
            end
        end
    end

    task automatic expect_eq(input string n, input int a, input int x);
        chk_n.push_back(n);
        chk_a.push_back(a);
        chk_e.push_back(x);
    endtask

    task automatic push_raw(input int cam, input logic [7:0] b);
        if (cam == 0) begin
            mem0[wp0[3:0]] = b;
            wp0 = wp0 + 5'd1;
        end else begin
            mem1[wp1[3:0]] = b;
            wp1 = wp1 + 5'd1;
        end
    endtask

    task automatic push_exp(input int cam, input logic [7:0] base, input logic sof);
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{d: 8'(base + 8'(i)), sof: sof && i == 0, eol: i == 3, cam: cam[0]});
    endtask

    task automatic line(input int cam, input logic [7:0] base, input logic sof);
        for (int i = 0; i < 4; i++) push_raw(cam, 8'(base + 8'(i)));
        push_exp(cam, base, sof);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        expect_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        int h, p, fc, idx, n;
        rst = 1'b1;
        start_stream = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            expect_eq("rst_busy", busy, 0);
            expect_eq("rst_flush", fifo_flush, 0);
            expect_eq("rst_valid", out_valid, 0);
            expect_eq("rst_outs", {out_data, out_sof, out_eol, out_cam, cam0_rdreq, cam1_rdreq}, 0);
            expect_eq("rst_frame", frame_cnt, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        expect_eq("flush_pulse", fifo_flush, 1);
        @(negedge clk);
        expect_eq("flush_once", fifo_flush, 0);
        expect_eq("busy_run", busy, 1);
        expect_eq("flush_cnt", flush_cnt, 1);

        @(posedge clk); #1;
        line(0, 8'hA0, 1'b1);
        line(1, 8'hB0, 1'b0);
        wait_drain();
        repeat (3) @(negedge clk);
        expect_eq("frame_after_pair1", frame_cnt, 0);
        @(posedge clk); #1;
        line(0, 8'hA4, 1'b0);
        line(1, 8'hB4, 1'b0);
        wait_drain();
        repeat (3) @(negedge clk);
        expect_eq("frame_after_pair2", frame_cnt, 1);
        @(posedge clk); #1;
        line(0, 8'hA8, 1'b1);
        line(1, 8'hB8, 1'b0);
        wait_drain();

        // cam1 has a full line but it is cam0's turn with only 3 bytes.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_raw(0, 8'(8'hC0 + 8'(i)));
        for (int i = 0; i < 4; i++) push_raw(1, 8'(8'hD0 + 8'(i)));
        h = hs_cnt;
        p = p1_cnt;
        repeat (10) @(negedge clk);
        expect_eq("starve_no_output", hs_cnt - h, 0);
        expect_eq("starve_no_cam1_pop", p1_cnt - p, 0);
        expect_eq("starve_valid", out_valid, 0);
        @(posedge clk); #1;
        push_raw(0, 8'hC3);
        push_exp(0, 8'hC0, 1'b0);
        push_exp(1, 8'hD0, 1'b0);
        wait_drain();
        repeat (3) @(negedge clk);
        expect_eq("frame_after_pair4", frame_cnt, 2);

        // Backpressure: alternate ready, one pop per ready-high cycle, data held otherwise.
        @(posedge clk); #1;
        out_ready = 1'b0;
        line(0, 8'hE0, 1'b1);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        expect_eq("bp_valid", out_valid, 1);
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1 out_ready = (k % 2) == 0;
            @(negedge clk);
            expect_eq("bp_rdreq", cam0_rdreq, int'(out_ready));
            expect_eq("bp_data", out_data, 8'hE0 + idx);
            if (out_ready) idx++;
        end
        @(posedge clk); #1 out_ready = 1'b1;

        // start_stream drops mid-line: the line still completes, then IDLE.
        h = hs_cnt;
        line(1, 8'hF0, 1'b0);
        n = 0;
        while (hs_cnt < h + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 start_stream = 1'b0;
        wait_drain();
        expect_eq("drop_line_bytes", hs_cnt - h, 4);
        repeat (3) @(negedge clk);
        expect_eq("drop_busy", busy, 0);

        // Drop while waiting for a line: back to IDLE, nothing sent.
        fc = flush_cnt;
        @(posedge clk); #1 start_stream = 1'b1;
        @(negedge clk);
        expect_eq("restart_flush", fifo_flush, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_raw(0, 8'(8'h70 + 8'(i)));
        h = hs_cnt;
        @(posedge clk); #1 start_stream = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_eq("wait_drop_busy", busy, 0);
        expect_eq("wait_drop_bytes", hs_cnt - h, 0);
        expect_eq("wait_drop_flushes", flush_cnt - fc, 1);
        expect_eq("leftover_expected", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
